// File: rtl/urisc_mem_arbiter_if.sv
// rtl/urisc_mem_arbiter_if.sv - requester and memory bus signals of the URISC memory arbiter
interface urisc_mem_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic              c_req;
  logic              c_we;
  logic              c_sel;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_done;
  logic              c_err;
  logic [DATA_W-1:0] c_rdata;

  logic              h_req;
  logic              h_we;
  logic              h_sel;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic              h_gnt;
  logic              h_done;
  logic              h_err;
  logic [DATA_W-1:0] h_rdata;

  logic [ADDR_W-1:0] MAR;
  logic [DATA_W-1:0] Data_out;
  logic              Data_CS;
  logic              Inst_CS;
  logic              Read;
  logic              Write;
  logic [DATA_W-1:0] Data_in;
  logic [DATA_W-1:0] Inst_in;

  modport slave (
    input  c_req, c_we, c_sel, c_addr, c_wdata,
    input  h_req, h_we, h_sel, h_addr, h_wdata,
    input  Data_in, Inst_in,
    output c_gnt, c_done, c_err, c_rdata,
    output h_gnt, h_done, h_err, h_rdata,
    output MAR, Data_out, Data_CS, Inst_CS, Read, Write
  );

  modport master (
    output c_req, c_we, c_sel, c_addr, c_wdata,
    output h_req, h_we, h_sel, h_addr, h_wdata,
    output Data_in, Inst_in,
    input  c_gnt, c_done, c_err, c_rdata,
    input  h_gnt, h_done, h_err, h_rdata,
    input  MAR, Data_out, Data_CS, Inst_CS, Read, Write
  );
endinterface

// File: rtl/urisc_mem_arbiter.sv
// rtl/urisc_mem_arbiter.sv - round-robin arbiter sharing the URISC Mem/ROM bus between core and host
module urisc_mem_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input logic clk,
  input logic reset,
  urisc_mem_arbiter_if.slave arb_if
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  localparam logic       OWN_CORE = 1'b0;
  localparam logic       OWN_HOST = 1'b1;
  localparam logic [2:0] CNT_LAST = 3'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic              sel_q, sel_d;
  logic              err_flag_q, err_flag_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d, h_rdata_q, h_rdata_d;
  logic              c_gnt_q, c_gnt_d, h_gnt_q, h_gnt_d;
  logic              c_done_q, c_done_d, h_done_q, h_done_d;
  logic              c_err_q, c_err_d, h_err_q, h_err_d;
  logic              dcs_q, dcs_d, ics_q, ics_d, rd_q, rd_d, wr_q, wr_d;

  // Host wins when it is the sole requester or when both ask and the core went last.
  logic              win;
  logic              r_we, r_sel;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] mem_rdata;

  assign win       = arb_if.h_req & (~arb_if.c_req | (last_q == OWN_CORE));
  assign r_we      = win ? arb_if.h_we    : arb_if.c_we;
  assign r_sel     = win ? arb_if.h_sel   : arb_if.c_sel;
  assign r_addr    = win ? arb_if.h_addr  : arb_if.c_addr;
  assign r_wdata   = win ? arb_if.h_wdata : arb_if.c_wdata;
  assign mem_rdata = sel_q ? arb_if.Inst_in : arb_if.Data_in;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    we_d       = we_q;
    sel_d      = sel_q;
    err_flag_d = err_flag_q;
    cnt_d      = cnt_q;
    mar_d      = mar_q;
    dout_d     = dout_q;
    c_rdata_d  = c_rdata_q;
    h_rdata_d  = h_rdata_q;
    c_gnt_d    = 1'b0;
    h_gnt_d    = 1'b0;
    c_done_d   = 1'b0;
    h_done_d   = 1'b0;
    c_err_d    = 1'b0;
    h_err_d    = 1'b0;
    dcs_d      = 1'b0;
    ics_d      = 1'b0;
    rd_d       = 1'b0;
    wr_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_if.c_req || arb_if.h_req) begin
          owner_d    = win;
          last_d     = win;
          we_d       = r_we;
          sel_d      = r_sel;
          err_flag_d = r_we & r_sel;
          mar_d      = r_addr;
          c_gnt_d    = ~win;
          h_gnt_d    = win;
          if (!r_we) begin
            rd_d  = 1'b1;
            dcs_d = ~r_sel;
            ics_d = r_sel;
          end else if (!r_sel) begin
            wr_d   = 1'b1;
            dcs_d  = 1'b1;
            dout_d = r_wdata;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = 3'd0;
        if (we_q) begin
          c_done_d = (owner_q == OWN_CORE);
          h_done_d = (owner_q == OWN_HOST);
          c_err_d  = (owner_q == OWN_CORE) & err_flag_q;
          h_err_d  = (owner_q == OWN_HOST) & err_flag_q;
          state_d  = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          if (owner_q == OWN_HOST) h_rdata_d = mem_rdata;
          else                     c_rdata_d = mem_rdata;
          c_done_d = (owner_q == OWN_CORE);
          h_done_d = (owner_q == OWN_HOST);
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_CORE;
      last_q     <= OWN_HOST;
      we_q       <= 1'b0;
      sel_q      <= 1'b0;
      err_flag_q <= 1'b0;
      cnt_q      <= 3'd0;
      mar_q      <= '0;
      dout_q     <= '0;
      c_rdata_q  <= '0;
      h_rdata_q  <= '0;
      c_gnt_q    <= 1'b0;
      h_gnt_q    <= 1'b0;
      c_done_q   <= 1'b0;
      h_done_q   <= 1'b0;
      c_err_q    <= 1'b0;
      h_err_q    <= 1'b0;
      dcs_q      <= 1'b0;
      ics_q      <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      err_flag_q <= err_flag_d;
      cnt_q      <= cnt_d;
      mar_q      <= mar_d;
      dout_q     <= dout_d;
      c_rdata_q  <= c_rdata_d;
      h_rdata_q  <= h_rdata_d;
      c_gnt_q    <= c_gnt_d;
      h_gnt_q    <= h_gnt_d;
      c_done_q   <= c_done_d;
      h_done_q   <= h_done_d;
      c_err_q    <= c_err_d;
      h_err_q    <= h_err_d;
      dcs_q      <= dcs_d;
      ics_q      <= ics_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  assign arb_if.c_gnt    = c_gnt_q;
  assign arb_if.h_gnt    = h_gnt_q;
  assign arb_if.c_done   = c_done_q;
  assign arb_if.h_done   = h_done_q;
  assign arb_if.c_err    = c_err_q;
  assign arb_if.h_err    = h_err_q;
  assign arb_if.c_rdata  = c_rdata_q;
  assign arb_if.h_rdata  = h_rdata_q;
  assign arb_if.MAR      = mar_q;
  assign arb_if.Data_out = dout_q;
  assign arb_if.Data_CS  = dcs_q;
  assign arb_if.Inst_CS  = ics_q;
  assign arb_if.Read     = rd_q;
  assign arb_if.Write    = wr_q;

endmodule

// File: tb/tb_urisc_mem_arbiter.sv
// tb/tb_urisc_mem_arbiter.sv - directed self-checking bench for urisc_mem_arbiter
module tb_urisc_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  urisc_mem_arbiter_if #(.ADDR_W(9), .DATA_W(16)) ba ();
  urisc_mem_arbiter_if #(.ADDR_W(9), .DATA_W(16)) bb ();

  urisc_mem_arbiter #(.ADDR_W(9), .DATA_W(16), .MEM_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .arb_if(ba.slave)
  );
  urisc_mem_arbiter #(.ADDR_W(9), .DATA_W(16), .MEM_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .arb_if(bb.slave)
  );

  // Memory models: data Mem latency 1 on bus A, ROM latency 3 on bus B.
  logic [15:0] mem_a [512];
  logic [15:0] rom_a [512];
  logic [15:0] rom_b [512];
  logic [15:0] a_dq, a_iq;
  logic [15:0] b_ip [3];

  initial begin
    for (int i = 0; i < 512; i++) begin
      rom_a[i] = 16'h0;
      rom_b[i] = 16'h0;
    end
    rom_b[9'h020] = 16'h0A0B;
  end

  always @(posedge clk) begin
    if (reset) mem_a[9'h005] <= 16'h1234;
    else if (ba.Write && ba.Data_CS) mem_a[ba.MAR] <= ba.Data_out;
    a_dq    <= (ba.Read && ba.Data_CS) ? mem_a[ba.MAR] : 16'hDEAD;
    a_iq    <= (ba.Read && ba.Inst_CS) ? rom_a[ba.MAR] : 16'hDEAD;
    b_ip[0] <= (bb.Read && bb.Inst_CS) ? rom_b[bb.MAR] : 16'hDEAD;
    b_ip[1] <= b_ip[0];
    b_ip[2] <= b_ip[1];
  end

  assign ba.Data_in = a_dq;
  assign ba.Inst_in = a_iq;
  assign bb.Data_in = 16'hDEAD;
  assign bb.Inst_in = b_ip[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input bit host, input bit req, input bit we, input bit sel,
                         input logic [8:0] addr, input logic [15:0] wdata);
    if (host) begin
      ba.h_req = req; ba.h_we = we; ba.h_sel = sel; ba.h_addr = addr; ba.h_wdata = wdata;
    end else begin
      ba.c_req = req; ba.c_we = we; ba.c_sel = sel; ba.c_addr = addr; ba.c_wdata = wdata;
    end
  endtask

  // Single access on bus A from IDLE with timing checked cycle by cycle.
  task automatic access_a(input bit host, input bit we, input bit sel, input logic [8:0] addr,
                          input logic [15:0] wdata, input logic [15:0] exp_rdata, input bit exp_err);
    drive_a(host, 1'b1, we, sel, addr, wdata);
    step();
    check_eq("gnt_owner",  host ? ba.h_gnt : ba.c_gnt, 1);
    check_eq("gnt_other",  host ? ba.c_gnt : ba.h_gnt, 0);
    check_eq("mar",        ba.MAR, addr);
    check_eq("read",       ba.Read, !we);
    check_eq("write",      ba.Write, we && !sel);
    check_eq("data_cs",    ba.Data_CS, !sel);
    check_eq("inst_cs",    ba.Inst_CS, sel && !we);
    if (we && !sel) check_eq("data_out", ba.Data_out, wdata);
    drive_a(host, 1'b0, ~we, ~sel, ~addr, 16'h0);
    if (!we) begin
      step();
      check_eq("done_early", host ? ba.h_done : ba.c_done, 0);
    end
    step();
    check_eq("done_owner", host ? ba.h_done : ba.c_done, 1);
    check_eq("done_other", host ? ba.c_done : ba.h_done, 0);
    check_eq("err_owner",  host ? ba.h_err : ba.c_err, exp_err);
    check_eq("strobes_off", {ba.Read, ba.Write, ba.Data_CS, ba.Inst_CS}, 0);
    if (!we) check_eq("rdata", host ? ba.h_rdata : ba.c_rdata, exp_rdata);
    step();
    check_eq("done_clear", host ? ba.h_done : ba.c_done, 0);
  endtask

  initial begin
    drive_a(1'b0, 1'b0, 1'b0, 1'b0, 9'h0, 16'h0);
    drive_a(1'b1, 1'b0, 1'b0, 1'b0, 9'h0, 16'h0);
    bb.c_req = 1'b0; bb.c_we = 1'b0; bb.c_sel = 1'b0; bb.c_addr = 9'h0; bb.c_wdata = 16'h0;
    bb.h_req = 1'b0; bb.h_we = 1'b0; bb.h_sel = 1'b0; bb.h_addr = 9'h0; bb.h_wdata = 16'h0;

    step();
    step();
    check_eq("rst_pulses", {ba.c_gnt, ba.h_gnt, ba.c_done, ba.h_done, ba.c_err, ba.h_err}, 0);
    check_eq("rst_strobes", {ba.Read, ba.Write, ba.Data_CS, ba.Inst_CS}, 0);
    check_eq("rst_mar", ba.MAR, 0);
    check_eq("rst_dout", ba.Data_out, 0);
    check_eq("rst_rdata", {ba.c_rdata, ba.h_rdata}, 0);
    reset = 1'b0;
    step();

    access_a(1'b0, 1'b0, 1'b0, 9'h005, 16'h0,    16'h1234, 1'b0);
    access_a(1'b1, 1'b1, 1'b0, 9'h1FF, 16'hBEEF, 16'h0,    1'b0);
    access_a(1'b0, 1'b0, 1'b0, 9'h1FF, 16'h0,    16'hBEEF, 1'b0);
    access_a(1'b1, 1'b1, 1'b1, 9'h010, 16'h5555, 16'h0,    1'b1);

    // Both held high: core, host, core, host with a 4-cycle period.
    drive_a(1'b0, 1'b1, 1'b0, 1'b0, 9'h005, 16'h0);
    drive_a(1'b1, 1'b1, 1'b0, 1'b0, 9'h1FF, 16'h0);
    for (int k = 1; k <= 16; k++) begin
      step();
      check_eq($sformatf("rr_c_gnt_%0d", k), ba.c_gnt, (k == 1 || k == 9));
      check_eq($sformatf("rr_h_gnt_%0d", k), ba.h_gnt, (k == 5 || k == 13));
      if (k == 13) begin
        ba.c_req = 1'b0;
        ba.h_req = 1'b0;
      end
    end
    check_eq("rr_c_rdata", ba.c_rdata, 16'h1234);
    check_eq("rr_h_rdata", ba.h_rdata, 16'hBEEF);

    // Reset during WAIT of a core read.
    drive_a(1'b0, 1'b1, 1'b0, 1'b0, 9'h005, 16'h0);
    step();
    ba.c_req = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("wrst_pulses", {ba.c_gnt, ba.h_gnt, ba.c_done, ba.h_done, ba.c_err, ba.h_err}, 0);
    check_eq("wrst_strobes", {ba.Read, ba.Write, ba.Data_CS, ba.Inst_CS}, 0);
    check_eq("wrst_mar", ba.MAR, 0);
    check_eq("wrst_dout", ba.Data_out, 0);
    check_eq("wrst_rdata", {ba.c_rdata, ba.h_rdata}, 0);
    step();
    check_eq("wrst_no_done", ba.c_done, 0);

    // After reset last = host, so the core wins a tie; host follows with nominal timing.
    drive_a(1'b0, 1'b1, 1'b0, 1'b0, 9'h005, 16'h0);
    drive_a(1'b1, 1'b1, 1'b0, 1'b0, 9'h1FF, 16'h0);
    step();
    check_eq("post_c_gnt", ba.c_gnt, 1);
    check_eq("post_h_gnt", ba.h_gnt, 0);
    ba.c_req = 1'b0;
    step();
    step();
    check_eq("post_c_done", ba.c_done, 1);
    check_eq("post_c_rdata", ba.c_rdata, 16'h1234);
    step();
    step();
    check_eq("post_h_gnt2", ba.h_gnt, 1);
    check_eq("post_h_read", ba.Read & ba.Data_CS, 1);
    ba.h_req = 1'b0;
    step();
    check_eq("post_h_done_early", ba.h_done, 0);
    step();
    check_eq("post_h_done", ba.h_done, 1);
    check_eq("post_h_rdata", ba.h_rdata, 16'hBEEF);
    step();

    // MEM_LAT = 3 ROM read on bus B.
    bb.c_req = 1'b1; bb.c_we = 1'b0; bb.c_sel = 1'b1; bb.c_addr = 9'h020;
    step();
    check_eq("lat3_gnt", bb.c_gnt, 1);
    check_eq("lat3_ics_rd", {bb.Inst_CS, bb.Read, bb.Data_CS}, 3'b110);
    check_eq("lat3_mar", bb.MAR, 9'h020);
    bb.c_req = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      step();
      check_eq($sformatf("lat3_done_early_%0d", k), bb.c_done, 0);
    end
    step();
    check_eq("lat3_done", bb.c_done, 1);
    check_eq("lat3_rdata", bb.c_rdata, 16'h0A0B);
    step();
    check_eq("lat3_done_clear", bb.c_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
